// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit seven-segment driver. It double-buffers BCD digits so a frame never tears,
// blanks leading zeros, and blanks all anodes at the start of each digit slot.
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seven_seg,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_disp_digits;
  logic [3:0]    r_disp_dp;
  logic [15:0]   r_pend_digits;
  logic [3:0]    r_pend_dp;
  logic          r_pend_v;
  logic [6:0]    r_seg;
  logic          r_dp_n;
  logic [3:0]    r_an;
  logic          r_frame_done;

  logic          w_slot_end;
  logic          w_boundary;
  logic          w_gap;
  logic [3:0]    w_nib;
  logic [3:0]    w_zero;
  logic          w_lz_blank;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_n_nxt;
  logic [3:0]    w_an_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_OFF;
    endcase
  endfunction

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_boundary = w_slot_end && (r_idx == 2'd3);
  assign w_gap      = (r_cnt < GAP_END);

  // Slot timing: cnt walks through one slot, idx advances once per slot.
  // NOTE: every clocked process uses non-blocking assignments so all registers update
  // from the same pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Pending/display double buffer. A load coinciding with the boundary still commits the
  // older pending value, and the new value waits for the following frame.
  // NOTE: both buffers are ordinary registers, not a memory array, so they reset cleanly
  // and a reset discards any pending value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_disp_digits <= '0;
      r_disp_dp     <= '0;
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_v      <= 1'b0;
    end else begin
      if (w_boundary && r_pend_v) begin
        r_disp_digits <= r_pend_digits;
        r_disp_dp     <= r_pend_dp;
      end
      if (load) begin
        r_pend_digits <= digits;
        r_pend_dp     <= dp;
        r_pend_v      <= 1'b1;
      end else if (w_boundary) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  assign w_zero[0] = (r_disp_digits[3:0]   == 4'd0);
  assign w_zero[1] = (r_disp_digits[7:4]   == 4'd0);
  assign w_zero[2] = (r_disp_digits[11:8]  == 4'd0);
  assign w_zero[3] = (r_disp_digits[15:12] == 4'd0);

  // NOTE: each combinational block assigns a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_nib = r_disp_digits[3:0];
    case (r_idx)
      2'd1:    w_nib = r_disp_digits[7:4];
      2'd2:    w_nib = r_disp_digits[11:8];
      2'd3:    w_nib = r_disp_digits[15:12];
      default: w_nib = r_disp_digits[3:0];
    endcase
  end

  // A digit is a leading zero only if it and every digit to its left are zero;
  // blank_lz acts live on the display rather than through the buffer.
  always_comb begin
    w_lz_blank = 1'b0;
    if (blank_lz) begin
      case (r_idx)
        2'd3:    w_lz_blank = w_zero[3];
        2'd2:    w_lz_blank = &w_zero[3:2];
        2'd1:    w_lz_blank = &w_zero[3:1];
        default: w_lz_blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_an_nxt   = 4'b1111;
    w_seg_nxt  = SEG_OFF;
    w_dp_n_nxt = 1'b1;
    if (!w_gap) begin
      w_an_nxt   = ~(4'b0001 << r_idx);
      w_seg_nxt  = w_lz_blank ? SEG_OFF : bcd_to_seg(w_nib);
      w_dp_n_nxt = ~r_disp_dp[r_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an         <= 4'b1111;
      r_seg        <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp_n       <= w_dp_n_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign an         = r_an;
  assign seven_seg  = r_seg;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with an 8-cycle slot and a 2-cycle blank gap.
// Expected frames are queued at load time and popped when the frame is displayed.
module tb_seg_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seven_seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_done;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz;
    logic [27:0] seg;   // {slot3, slot2, slot1, slot0}
    logic [3:0]  dpn;   // dp_n per slot
  } vec_t;

  typedef struct packed {
    logic        lz;
    logic [27:0] seg;
    logic [3:0]  dpn;
  } exp_t;

  vec_t tbl [8];
  exp_t q [$];

  seg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .digits    (digits),
    .dp        (dp),
    .load      (load),
    .blank_lz  (blank_lz),
    .seven_seg (seven_seg),
    .dp_n      (dp_n),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"},  an,         32'hf);
    check({tag, "_seg"}, seven_seg,  32'h7f);
    check({tag, "_dpn"}, dp_n,       32'h1);
    check({tag, "_fd"},  frame_done, 32'h0);
  endtask

  task automatic wait_fd(input int budget);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    check("frame_done_timeout", {31'd0, found}, 32'h1);
  endtask

  // Called at the negedge where frame_done is seen; checks a full frame and ends at the
  // next frame_done negedge. Optionally drives a load at offset late_off.
  task automatic check_frame(input exp_t e, input int late_off,
                             input logic [15:0] late_d, input logic [3:0] late_dp);
    logic [3:0] exp_an;
    int s;
    int j;
    for (int off = 1; off <= 32; off++) begin
      @(negedge clk);
      load = 1'b0;
      s = (off - 1) / 8;
      j = (off - 1) % 8;
      if (j < 2) begin
        check($sformatf("gap%0d_an", s),  an,        32'hf);
        check($sformatf("gap%0d_seg", s), seven_seg, 32'h7f);
        check($sformatf("gap%0d_dpn", s), dp_n,      32'h1);
      end else begin
        exp_an = ~(4'b0001 << s);
        check($sformatf("slot%0d_an", s),  an,        {28'd0, exp_an});
        check($sformatf("slot%0d_seg", s), seven_seg, {25'd0, e.seg[s*7 +: 7]});
        check($sformatf("slot%0d_dpn", s), dp_n,      {31'd0, e.dpn[s]});
      end
      check($sformatf("frame_done_off%0d", off), frame_done, (off == 32) ? 32'h1 : 32'h0);
      if (off == late_off) begin
        digits = late_d;
        dp     = late_dp;
        load   = 1'b1;
      end
    end
  endtask

  initial begin
    exp_t e;
    exp_t zero_exp;

    tbl[0] = '{16'h1234, 4'b0010, 1'b0,
               {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1101};
    tbl[1] = '{16'h0050, 4'b0000, 1'b1,
               {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 4'b1111};
    tbl[2] = '{16'h0050, 4'b0000, 1'b0,
               {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'b1111};
    tbl[3] = '{16'h00A7, 4'b0000, 1'b1,
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}, 4'b1111};
    tbl[4] = '{16'h0000, 4'b1111, 1'b1,
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b0000};
    tbl[5] = '{16'h9876, 4'b1000, 1'b1,
               {7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000}, 4'b0111};
    tbl[6] = '{16'h0305, 4'b0100, 1'b1,
               {7'b1111111, 7'b0000110, 7'b0000001, 7'b0100100}, 4'b1011};
    tbl[7] = '{16'hFEDC, 4'b0001, 1'b0,
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 4'b1110};
    zero_exp = '{1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111};

    reset = 1'b0; digits = '0; dp = '0; load = 1'b0; blank_lz = 1'b0;

    // Reset state, then the first slot and first frame_done after release.
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k <= 2 || k == 9) begin
        check($sformatf("boot%0d_an", k),  an,        32'hf);
        check($sformatf("boot%0d_seg", k), seven_seg, 32'h7f);
      end else if (k <= 8) begin
        check($sformatf("boot%0d_an", k),  an,        32'he);
        check($sformatf("boot%0d_seg", k), seven_seg, 32'h01);
        check($sformatf("boot%0d_dpn", k), dp_n,      32'h1);
      end
      check($sformatf("boot%0d_fd", k), frame_done, (k == 32) ? 32'h1 : 32'h0);
    end

    // Table vectors: each load is made at a frame start; the frame in progress must still
    // show the previous value, and the loaded value appears one frame later.
    q.push_back(zero_exp);
    wait_fd(40);
    for (int i = 0; i < 8; i++) begin
      e = q.pop_front();
      blank_lz = e.lz;
      digits = tbl[i].digits;
      dp     = tbl[i].dp;
      load   = 1'b1;
      q.push_back('{tbl[i].lz, tbl[i].seg, tbl[i].dpn});
      check_frame(e, 0, 16'h0, 4'h0);
    end

    // Last load before the boundary wins.
    e = q.pop_front();
    blank_lz = e.lz;
    digits = 16'h5555; dp = 4'b0000; load = 1'b1;
    check_frame(e, 20, 16'h0042, 4'b0001);
    q.push_back('{1'b1, {7'b1111111, 7'b1111111, 7'b1001100, 7'b0010010}, 4'b1110});

    // Load in the boundary cycle: 1111 shows next frame, 2222 the frame after.
    e = q.pop_front();
    blank_lz = e.lz;
    digits = 16'h1111; dp = 4'b0000; load = 1'b1;
    q.push_back('{1'b0, {4{7'b1001111}}, 4'b1111});
    check_frame(e, 31, 16'h2222, 4'b0000);
    q.push_back('{1'b0, {4{7'b0010010}}, 4'b1111});
    e = q.pop_front();
    blank_lz = e.lz;
    check_frame(e, 0, 16'h0, 4'h0);
    e = q.pop_front();
    blank_lz = e.lz;
    check_frame(e, 0, 16'h0, 4'h0);

    // Reset mid-slot2 with a load pending: immediate reset values, pending lost.
    digits = 16'h4321; dp = 4'b1111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("midreset");
    repeat (3) @(negedge clk);
    check_reset_vals("held");
    reset = 1'b1;
    blank_lz = 1'b0;
    q.delete();
    q.push_back(zero_exp);
    wait_fd(40);
    e = q.pop_front();
    check_frame(e, 0, 16'h0, 4'h0);
    check("queue_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
